// File: rtl/alu_bist.sv
// Built-in self test for a 32-bit ALU: drives an 8-entry vector table and checks result/zero.
// Define ALU_BIST_CAPTURE_EN to keep the alu_result seen at the first failing vector.
//
// state | meaning
// IDLE  | waiting for start, ALU operands held at 0
// DRIVE | register vector idx onto the ALU operand outputs
// CHECK | compare ALU result/zero against the expected entry
// DONE  | run finished, pass/fail_idx valid until next start
module alu_bist #(
   parameter bit STOP_ON_FAIL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [2:0]  fail_idx,
   output logic [31:0] fail_result
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  idx, idx_nxt;
   logic        fail_seen;
   logic [31:0] vec_a, vec_b, vec_res;
   logic [3:0]  vec_ctrl;
   logic        vec_zero;
   logic        start_run, mismatch, record;

   always_comb begin
      vec_a    = '0;
      vec_b    = '0;
      vec_ctrl = '0;
      vec_res  = '0;
      vec_zero = 1'b0;
      case (idx)
         3'd0: begin vec_a = 32'd10;        vec_b = 32'd20;        vec_ctrl = 4'b0010; vec_res = 32'd30;        end
         3'd1: begin vec_a = 32'd50;        vec_b = 32'd20;        vec_ctrl = 4'b0110; vec_res = 32'd30;        end
         3'd2: begin vec_a = 32'd10;        vec_b = 32'd10;        vec_ctrl = 4'b0110; vec_res = 32'd0; vec_zero = 1'b1; end
         3'd3: begin vec_a = 32'hF0F0F0F0;  vec_b = 32'h0FF00FF0;  vec_ctrl = 4'b0000; vec_res = 32'h00F000F0;  end
         3'd4: begin vec_a = 32'hF0000000;  vec_b = 32'h0000000F;  vec_ctrl = 4'b0001; vec_res = 32'hF000000F;  end
         3'd5: begin vec_a = 32'd5;         vec_b = 32'd7;         vec_ctrl = 4'b0111; vec_res = 32'd1;         end
         3'd6: begin vec_a = 32'hFFFFFFFF;  vec_b = 32'd1;         vec_ctrl = 4'b0111; vec_res = 32'd1;         end
         default: begin vec_a = 32'hFFFFFFFF; vec_b = 32'd1;       vec_ctrl = 4'b0010; vec_res = 32'd0; vec_zero = 1'b1; end
      endcase
   end

   assign start_run = start && (state == IDLE || state == DONE);
   assign mismatch  = (state == CHECK) && ((alu_result != vec_res) || (alu_zero != vec_zero));
   assign record    = mismatch && !fail_seen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = DRIVE;
               idx_nxt   = '0;
            end
         end
         DRIVE: state_nxt = CHECK;
         CHECK: begin
            if ((mismatch && STOP_ON_FAIL) || idx == 3'd7) begin
               state_nxt = DONE;
            end else begin
               state_nxt = DRIVE;
               idx_nxt   = idx + 3'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands only change on DRIVE and return to 0 whenever the run ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_ctrl  <= '0;
         fail_seen <= 1'b0;
         fail_idx  <= '0;
      end else begin
         if (start_run) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            fail_seen <= 1'b0;
            fail_idx  <= '0;
         end else if (state == DRIVE) begin
            alu_a    <= vec_a;
            alu_b    <= vec_b;
            alu_ctrl <= vec_ctrl;
         end else if (state == CHECK && state_nxt == DONE) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
         end
         if (record) begin
            fail_seen <= 1'b1;
            fail_idx  <= idx;
         end
      end
   end

`ifdef ALU_BIST_CAPTURE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_result <= '0;
      end else if (start_run) begin
         fail_result <= '0;
      end else if (record) begin
         fail_result <= alu_result;
      end
   end
`else
   assign fail_result = '0;
`endif

   assign busy = (state == DRIVE) || (state == CHECK);
   assign done = (state == DONE);
   assign pass = done && !fail_seen;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: two instances (stop on fail / run all) against a faultable ALU model.
module tb_alu_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   int   fault = 0;
   bit   sel = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   logic [31:0] a0, b0, res0, fr0, a1, b1, res1, fr1;
   logic [3:0]  c0, c1;
   logic        z0, busy0, done0, pass0, z1, busy1, done1, pass1;
   logic [2:0]  idx0, idx1;

   logic [31:0] a_s, b_s, fr_s;
   logic [3:0]  c_s;
   logic        busy_s, done_s, pass_s;
   logic [2:0]  idx_s;

`ifdef ALU_BIST_CAPTURE_EN
   localparam logic [31:0] FR_SUB = 32'd31;
`else
   localparam logic [31:0] FR_SUB = 32'd0;
`endif

   // fault: 0 good, 1 SUB result+1, 2 zero stuck at 0, 3 unsigned SLT
   function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] ctrl, input int flt);
      logic [31:0] r;
      logic        z;
      case (ctrl)
         4'b0010: r = a + b;
         4'b0110: r = a - b + ((flt == 1) ? 32'd1 : 32'd0);
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0111: r = (flt == 3) ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
         default: r = '0;
      endcase
      z = (flt == 2) ? 1'b0 : (r == 32'd0);
      return {z, r};
   endfunction

   always_comb {z0, res0} = alu_f(a0, b0, c0, fault);
   always_comb {z1, res1} = alu_f(a1, b1, c1, fault);

   alu_bist #(.STOP_ON_FAIL(1'b1)) u_dut_stop (
      .clk(clk), .rst_n(rst_n), .start(start),
      .alu_a(a0), .alu_b(b0), .alu_ctrl(c0), .alu_result(res0), .alu_zero(z0),
      .busy(busy0), .done(done0), .pass(pass0), .fail_idx(idx0), .fail_result(fr0)
   );

   alu_bist #(.STOP_ON_FAIL(1'b0)) u_dut_all (
      .clk(clk), .rst_n(rst_n), .start(start),
      .alu_a(a1), .alu_b(b1), .alu_ctrl(c1), .alu_result(res1), .alu_zero(z1),
      .busy(busy1), .done(done1), .pass(pass1), .fail_idx(idx1), .fail_result(fr1)
   );

   always_comb begin
      if (sel) begin
         a_s = a1; b_s = b1; c_s = c1; busy_s = busy1; done_s = done1;
         pass_s = pass1; idx_s = idx1; fr_s = fr1;
      end else begin
         a_s = a0; b_s = b0; c_s = c0; busy_s = busy0; done_s = done0;
         pass_s = pass0; idx_s = idx0; fr_s = fr0;
      end
   end

   logic [3:0] exp_ctrl [8] = '{4'b0010, 4'b0110, 4'b0110, 4'b0000,
                                4'b0001, 4'b0111, 4'b0111, 4'b0010};

   typedef struct {
      int          flt;
      bit          s;
      int          cyc;
      bit          ep;
      logic [2:0]  ei;
      logic [31:0] efr;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run(input int flt, input bit s, input int ecyc, input bit ep,
                      input logic [2:0] ei, input logic [31:0] efr,
                      input bit hold, input bit seq);
      int n;
      bit got;
      fault = flt;
      sel   = s;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_at_start", busy_s, 1);
      chk("done_cleared", done_s, 0);
      chk("pass_cleared", pass_s, 0);
      chk("fail_idx_cleared", idx_s, 0);
      chk("fail_result_cleared", fr_s, 0);
      if (!hold) start = 1'b0;
      n   = 0;
      got = 1'b0;
      while (n < 40 && !got) begin
         @(posedge clk);
         n++;
         #1;
         if (seq && (n % 2 == 1) && n <= 15)
            chk("alu_ctrl_seq", c_s, exp_ctrl[(n - 1) / 2]);
         if (done_s) got = 1'b1;
      end
      start = 1'b0;
      chk("run_cycles", n, ecyc);
      chk("busy_end", busy_s, 0);
      chk("pass", pass_s, ep);
      chk("fail_idx", idx_s, ei);
      chk("fail_result", fr_s, efr);
      chk("done_alu_ops", {a_s | b_s, c_s}, 0);
   endtask

   initial begin
      tbl[0] = '{0, 1'b0, 16, 1'b1, 3'd0, 32'd0};
      tbl[1] = '{1, 1'b0, 4,  1'b0, 3'd1, FR_SUB};
      tbl[2] = '{3, 1'b0, 14, 1'b0, 3'd6, 32'd0};
      tbl[3] = '{2, 1'b1, 16, 1'b0, 3'd2, 32'd0};
      tbl[4] = '{1, 1'b1, 16, 1'b0, 3'd1, FR_SUB};
      tbl[5] = '{3, 1'b1, 16, 1'b0, 3'd6, 32'd0};
      tbl[6] = '{0, 1'b1, 16, 1'b1, 3'd0, 32'd0};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stop_outputs", {a0, b0, c0, busy0, done0, pass0, idx0, fr0}, 0);
      chk("rst_all_outputs", {a1, b1, c1, busy1, done1, pass1, idx1, fr1}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("no_run_without_start", {busy0, done0, busy1, done1}, 0);

      run(0, 1'b0, 16, 1'b1, 3'd0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++)
         run(tbl[i].flt, tbl[i].s, tbl[i].cyc, tbl[i].ep, tbl[i].ei, tbl[i].efr, 1'b0, 1'b0);

      // reset in the middle of vector 4
      fault = 0;
      sel   = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("mid_run_ctrl_v4", c0, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outputs", {a0, b0, c0, busy0, done0, pass0, idx0, fr0}, 0);
      chk("mid_rst_all_busy", busy1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_after_mid_rst", {busy0, done0}, 0);
      run(0, 1'b0, 16, 1'b1, 3'd0, 32'd0, 1'b0, 1'b0);

      // start held high for the whole run, then restarted from DONE
      run(0, 1'b0, 16, 1'b1, 3'd0, 32'd0, 1'b1, 1'b1);
      run(1, 1'b0, 4, 1'b0, 3'd1, FR_SUB, 1'b1, 1'b0);
      run(0, 1'b0, 16, 1'b1, 3'd0, 32'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 The block SHALL have one parameter: STOP_ON_FAIL, default 1, 1 = end run at first mismatch, 0 = run all vectors.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle run request.
REQ-005 alu_a  output  32  ALU operand a.
REQ-006 alu_b  output  32  ALU operand b.
REQ-007 alu_ctrl  output  4  ALU op: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT.
REQ-008 alu_result  input  32  ALU result, combinational from alu_a/alu_b/alu_ctrl.
REQ-009 alu_zero  input  1  ALU zero flag.
REQ-010 busy  output  1  run in progress.
REQ-011 done  output  1  run finished; held until next start or reset.
REQ-012 pass  output  1  valid when done=1; 1 = all executed vectors matched.
REQ-013 fail_idx  output  3  index of first failing vector; 0 if none.
REQ-014 fail_result  output  32  alu_result captured at first failure (see Configuration).

Function
REQ-015 The block SHALL hold a fixed 8-entry table (a, b, ctrl, exp_result, exp_zero): 0 ADD 10,20->30,0; 1 SUB 50,20->30,0; 2 SUB 10,10->0,1; 3 AND F0F0F0F0,0FF00FF0->00F000F0,0; 4 OR F0000000,0000000F->F000000F,0; 5 SLT 5,7->1,0; 6 SLT FFFFFFFF,1->1,0 (signed); 7 ADD FFFFFFFF,1->0,1 (wrap).
REQ-016 FSM states SHALL be IDLE, DRIVE, CHECK, DONE.
REQ-017 IDLE/DONE + start=1 at edge T -> DRIVE at T; pass, fail_idx, fail_result, done cleared at same edge; busy=1 from T.
REQ-018 DRIVE SHALL register vector i onto alu_a/alu_b/alu_ctrl and go to CHECK next edge; outputs stable through CHECK.
REQ-019 CHECK SHALL compare alu_result and alu_zero against expected at end of cycle; any bit mismatch in either is a failure.
REQ-020 CHECK, match, i<7 -> DRIVE with i+1; match, i=7 -> DONE.
REQ-021 CHECK, first mismatch -> record fail_idx=i; STOP_ON_FAIL=1 -> DONE; STOP_ON_FAIL=0 -> continue; later mismatches SHALL NOT overwrite record.
REQ-022 Full run SHALL take 16 cycles: start at edge T, done=1 and busy=0 after edge T+16.
REQ-023 In DONE, pass SHALL be 1 iff no mismatch recorded.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 In IDLE and DONE, alu_a, alu_b, alu_ctrl SHALL be 0.

Reset
REQ-026 rst_n=0 SHALL immediately, regardless of state (including mid-run), force IDLE and drive alu_a/alu_b/alu_ctrl/busy/done/pass/fail_idx/fail_result to 0.
REQ-027 After rst_n deassertion, no run SHALL start without a start pulse.

Configuration
REQ-028 Macro ALU_BIST_CAPTURE_EN defined: fail_result SHALL hold alu_result sampled at first recorded failure, cleared on start/reset.
REQ-029 Macro ALU_BIST_CAPTURE_EN undefined: fail_result SHALL be constant 0 and no capture register SHALL be built; all other behaviour unchanged.

Verification
REQ-030 Reset then start with correct ALU -> busy 16 cycles, done=1, pass=1, fail_idx=0; alu_ctrl sequence 0010,0110,0110,0000,0001,0111,0111,0010.
REQ-031 ALU faulted to return result+1 on SUB, STOP_ON_FAIL=1 -> done after 4 cycles, pass=0, fail_idx=1, fail_result=31 (capture on).
REQ-032 ALU with zero stuck at 0, STOP_ON_FAIL=0 -> done after 16 cycles, pass=0, fail_idx=2; macro off -> fail_result=0.
REQ-033 rst_n pulsed low during vector 4 -> all outputs 0 immediately; next start runs full 16-cycle pass.
REQ-034 start asserted every cycle during run -> run unaffected, done after edge T+16; start in DONE -> pass/done cleared, new run begins.
REQ-035 ALU with unsigned SLT -> vector 6 fails: fail_idx=6, fail_result=0 (capture on).
